// File: rtl/uart_rx_pkg.sv
// Shared constants, FSM state type and baud divider helper for the UART receiver.
package uart_rx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Bit positions of the per-word error flags.
    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_BRK = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Rounded clk cycles per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is taken only when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority voting, buffered word stream and idle/end-of-packet flags.
// Stream handshake: a word transfers on every clk edge where m_valid and m_ready are both high;
// m_data/m_err hold steady while m_valid is high and m_ready is low, and read 0 when empty.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int IDLE_BITS  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          m_data,
    output logic [2:0]                    m_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          rx_idle,
    output logic                          rx_eop
);
    localparam int   DIV         = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int   DCW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   SCW         = $clog2(OVERSAMPLE);
    localparam int   VOTE_POS    = OVERSAMPLE / 2 + 1;
    localparam int   IDLE_MAX    = IDLE_BITS * OVERSAMPLE;
    localparam int   ICW         = $clog2(IDLE_MAX + 1);
    localparam int   FW          = DATA_BITS + 3;
    localparam logic PAR_ODD_SEL = (PARITY == PAR_ODD);

    logic [DCW-1:0]       div_cnt_q, div_cnt_d;
    logic                 tick;
    logic [1:0]           sync_q, sync_d;
    logic                 rxd_s;
    logic [2:0]           smp_q, smp_d;
    logic                 vote;
    rx_state_e            state_q, state_d;
    logic [SCW-1:0]       smp_cnt_q, smp_cnt_d, cnt_nxt;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 any_one_q, any_one_d;
    logic                 lock_q, lock_d;
    logic                 push_w, pop_w;
    logic [2:0]           err_w;
    logic [ICW-1:0]       idle_cnt_q, idle_cnt_d;
    logic                 rx_idle_q, rx_idle_d;
    logic                 rx_eop_q, rx_eop_d;
    logic                 pend_q, pend_d;
    logic                 overrun_q, overrun_d;
    logic [FW-1:0]        fifo_dout;
    logic                 fifo_full, fifo_empty;

    assign tick  = (div_cnt_q == DCW'(DIV - 1));
    assign rxd_s = sync_q[1];

    // Free-running tick divider, 2-flop synchroniser and sample history with majority vote.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        sync_d    = {sync_q[0], rxd};
        smp_d     = tick ? {smp_q[1:0], rxd_s} : smp_q;
        vote      = (smp_d[0] & smp_d[1]) | (smp_d[0] & smp_d[2]) | (smp_d[1] & smp_d[2]);
    end

    // Receive FSM: votes once per bit at the third of the three mid-bit samples.
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        any_one_d = any_one_q;
        lock_d    = lock_q;
        push_w    = 1'b0;
        cnt_nxt   = (smp_cnt_q == SCW'(OVERSAMPLE - 1)) ? '0 : smp_cnt_q + 1'b1;
        err_w          = '0;
        err_w[ERR_PAR] = par_err_q;
        err_w[ERR_FRM] = frm_err_q | ~vote;
        err_w[ERR_BRK] = ~(any_one_q | vote);
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (lock_q) begin
                        if (vote) lock_d = 1'b0;
                    end else if (!rxd_s) begin
                        state_d   = ST_START;
                        smp_cnt_d = '0;
                        bit_cnt_d = '0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        any_one_d = 1'b0;
                    end
                end
                default: smp_cnt_d = cnt_nxt;
            endcase
            if (state_q != ST_IDLE && cnt_nxt == SCW'(VOTE_POS)) begin
                case (state_q)
                    ST_START: state_d = vote ? ST_IDLE : ST_DATA;
                    ST_DATA: begin
                        data_d    = {vote, data_q[DATA_BITS-1:1]};
                        any_one_d = any_one_q | vote;
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        par_err_d = ((^data_q) ^ vote) != PAR_ODD_SEL;
                        any_one_d = any_one_q | vote;
                        state_d   = ST_STOP;
                    end
                    ST_STOP: begin
                        any_one_d = any_one_q | vote;
                        if (!vote) frm_err_d = 1'b1;
                        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                            push_w  = 1'b1;
                            state_d = ST_IDLE;
                            lock_d  = err_w[ERR_BRK];
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Idle detection, end-of-packet pulse and sticky overrun.
    always_comb begin
        pop_w      = m_valid && m_ready;
        idle_cnt_d = idle_cnt_q;
        if (state_q != ST_IDLE) begin
            idle_cnt_d = '0;
        end else if (tick) begin
            if (!rxd_s) idle_cnt_d = '0;
            else if (idle_cnt_q != ICW'(IDLE_MAX)) idle_cnt_d = idle_cnt_q + 1'b1;
        end
        rx_idle_d = (idle_cnt_d == ICW'(IDLE_MAX));
        rx_eop_d  = rx_idle_d && !rx_idle_q && pend_q;
        pend_d    = push_w ? 1'b1 : (rx_eop_d ? 1'b0 : pend_q);
        overrun_d = (push_w && fifo_full && !pop_w) ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
    end

    // State and datapath registers; synchroniser and samples reset to line-idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            sync_q     <= 2'b11;
            smp_q      <= 3'b111;
            state_q    <= ST_IDLE;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            any_one_q  <= 1'b0;
            lock_q     <= 1'b0;
            idle_cnt_q <= '0;
            rx_idle_q  <= 1'b0;
            rx_eop_q   <= 1'b0;
            pend_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sync_q     <= sync_d;
            smp_q      <= smp_d;
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            any_one_q  <= any_one_d;
            lock_q     <= lock_d;
            idle_cnt_q <= idle_cnt_d;
            rx_idle_q  <= rx_idle_d;
            rx_eop_q   <= rx_eop_d;
            pend_q     <= pend_d;
            overrun_q  <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_w),
        .pop   (pop_w),
        .din   ({err_w, data_q}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_dout[DATA_BITS-1:0];
    assign m_err   = fifo_empty ? '0 : fifo_dout[FW-1:DATA_BITS];
    assign overrun = overrun_q;
    assign rx_idle = rx_idle_q;
    assign rx_eop  = rx_eop_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receiver configurations (8N1, 8E1, 7O2) at 64 clk per bit.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rxd_v;
  logic [2:0] m_ready_v;
  logic [2:0] ovr_clr_v;

  logic [7:0] m_data_a;  logic [2:0] m_err_a;  logic m_valid_a;  logic [2:0] fifo_count_a;
  logic       overrun_a, rx_idle_a, rx_eop_a;
  logic [7:0] m_data_b;  logic [2:0] m_err_b;  logic m_valid_b;  logic [2:0] fifo_count_b;
  logic       overrun_b, rx_idle_b, rx_eop_b;
  logic [6:0] m_data_c;  logic [2:0] m_err_c;  logic m_valid_c;  logic [2:0] fifo_count_c;
  logic       overrun_c, rx_idle_c, rx_eop_c;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int eop_cnt;

  // clock / reset block
  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(6_400_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .IDLE_BITS(2)) u_a (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .m_data(m_data_a), .m_err(m_err_a),
    .m_valid(m_valid_a), .m_ready(m_ready_v[0]), .fifo_count(fifo_count_a),
    .overrun(overrun_a), .ovr_clr(ovr_clr_v[0]), .rx_idle(rx_idle_a), .rx_eop(rx_eop_a));

  uart_rx_fifo #(.CLK_FREQ(6_400_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .IDLE_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .m_data(m_data_b), .m_err(m_err_b),
    .m_valid(m_valid_b), .m_ready(m_ready_v[1]), .fifo_count(fifo_count_b),
    .overrun(overrun_b), .ovr_clr(ovr_clr_v[1]), .rx_idle(rx_idle_b), .rx_eop(rx_eop_b));

  uart_rx_fifo #(.CLK_FREQ(6_400_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(7),
                 .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .IDLE_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .m_data(m_data_c), .m_err(m_err_c),
    .m_valid(m_valid_c), .m_ready(m_ready_v[2]), .fifo_count(fifo_count_c),
    .overrun(overrun_c), .ovr_clr(ovr_clr_v[2]), .rx_idle(rx_idle_c), .rx_eop(rx_eop_c));

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tx_bit(input int d, input logic b);
    rxd_v[d] = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // start bit, then n bits of 'bits' LSB first (data, parity, stops), then line high
  task automatic tx_frame(input int d, input int n, input logic [15:0] bits);
    tx_bit(d, 1'b0);
    for (int i = 0; i < n; i++) tx_bit(d, bits[i]);
    rxd_v[d] = 1'b1;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic pop(input int d);
    m_ready_v[d] = 1'b1;
    @(negedge clk);
    m_ready_v[d] = 1'b0;
  endtask

  task automatic count_eop(input int clks);
    eop_cnt = 0;
    repeat (clks) begin
      @(negedge clk);
      eop_cnt += int'(rx_eop_a);
    end
  endtask

  initial begin
    rst       = 1'b1;
    rxd_v     = 3'b111;
    m_ready_v = 3'b000;
    ovr_clr_v = 3'b000;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_count", fifo_count_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_m_err", m_err_a, 0);
    chk("rst_overrun", overrun_a, 0);
    chk("rst_idle", rx_idle_a, 0);
    chk("rst_eop", rx_eop_a, 0);
    rst = 1'b0;

    // idle after reset with nothing received: rx_idle rises, no eop
    count_eop(3 * BIT_CLKS);
    chk("boot_idle", rx_idle_a, 1);
    chk("boot_no_eop", eop_cnt, 0);

    // 1. 8N1 0xA5, 0x3C
    tx_frame(0, 9, {7'b0, 1'b1, 8'hA5});
    chk("t1_idle_dropped", rx_idle_a, 0);
    chk("t1_count1", fifo_count_a, 1);
    tx_frame(0, 9, {7'b0, 1'b1, 8'h3C});
    chk("t1_count2", fifo_count_a, 2);
    chk("t1_valid", m_valid_a, 1);
    chk("t1_data0", m_data_a, 8'hA5);
    chk("t1_err0", m_err_a, 3'b000);
    count_eop(3 * BIT_CLKS);
    chk("t1_eop_once", eop_cnt, 1);
    chk("t1_idle", rx_idle_a, 1);
    pop(0);
    chk("t1_data1", m_data_a, 8'h3C);
    chk("t1_err1", m_err_a, 3'b000);
    pop(0);
    chk("t1_empty", m_valid_a, 0);
    chk("t1_data_zero", m_data_a, 0);
    count_eop(2 * BIT_CLKS);
    chk("t1_no_second_eop", eop_cnt, 0);

    // 2. 8E1: 0x07 has three ones, so even parity needs parity bit 1
    tx_frame(1, 10, {6'b0, 1'b1, 1'b0, 8'h07});
    tx_frame(1, 10, {6'b0, 1'b1, 1'b1, 8'h07});
    chk("t2_count", fifo_count_b, 2);
    chk("t2_data_bad", m_data_b, 8'h07);
    chk("t2_err_bad", m_err_b, 3'b001);
    pop(1);
    chk("t2_data_good", m_data_b, 8'h07);
    chk("t2_err_good", m_err_b, 3'b000);
    pop(1);

    // 3. 7O2: 0x55 (four ones, parity 1) with second stop 0; then 0x2A (three ones, parity 0)
    tx_frame(2, 10, {6'b0, 1'b0, 1'b1, 1'b1, 7'h55});
    wait_bits(1);
    tx_frame(2, 10, {6'b0, 1'b1, 1'b1, 1'b0, 7'h2A});
    chk("t3_count", fifo_count_c, 2);
    chk("t3_data_frm", m_data_c, 7'h55);
    chk("t3_err_frm", m_err_c, 3'b010);
    pop(2);
    chk("t3_data_next", m_data_c, 7'h2A);
    chk("t3_err_next", m_err_c, 3'b000);
    pop(2);

    // 4. break: 20 bit-times low, then high
    rxd_v[0] = 1'b0;
    wait_bits(20);
    chk("t4_count_low", fifo_count_a, 1);
    rxd_v[0] = 1'b1;
    wait_bits(3);
    chk("t4_count_high", fifo_count_a, 1);
    chk("t4_data", m_data_a, 0);
    chk("t4_err", m_err_a, 3'b110);
    pop(0);
    tx_frame(0, 9, {7'b0, 1'b1, 8'h81});
    chk("t4_after_count", fifo_count_a, 1);
    chk("t4_after_data", m_data_a, 8'h81);
    chk("t4_after_err", m_err_a, 3'b000);
    pop(0);

    // 5. overrun with depth 4
    for (int v = 1; v <= 5; v++) tx_frame(0, 9, {7'b0, 1'b1, 8'(v)});
    chk("t5_count_full", fifo_count_a, 4);
    chk("t5_overrun", overrun_a, 1);
    for (int v = 1; v <= 4; v++) begin
      chk("t5_pop_data", m_data_a, v);
      pop(0);
    end
    chk("t5_empty", m_valid_a, 0);
    chk("t5_overrun_sticky", overrun_a, 1);
    ovr_clr_v[0] = 1'b1;
    @(negedge clk);
    ovr_clr_v[0] = 1'b0;
    chk("t5_overrun_clr", overrun_a, 0);

    // 6. 20-clk glitch, then reset during bit 3 of 0x5A, then a clean 0x5A
    rxd_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    rxd_v[0] = 1'b1;
    wait_bits(12);
    chk("t6_glitch_valid", m_valid_a, 0);
    chk("t6_glitch_count", fifo_count_a, 0);
    tx_bit(0, 1'b0);
    tx_bit(0, 1'b0);
    tx_bit(0, 1'b1);
    tx_bit(0, 1'b0);
    rxd_v[0] = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_bits(12);
    chk("t6_rst_valid", m_valid_a, 0);
    chk("t6_rst_count", fifo_count_a, 0);
    tx_frame(0, 9, {7'b0, 1'b1, 8'h5A});
    chk("t6_clean_count", fifo_count_a, 1);
    chk("t6_clean_data", m_data_a, 8'h5A);
    chk("t6_clean_err", m_err_a, 3'b000);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
